// File: rtl/td4_program_loader_if.sv
// Program-load and instruction-fetch bus between the TD4 test top and its program store.
// The master end loads bytes and presents pc; the slave end returns the fetched instruction.
interface td4_program_loader_if;
  logic       load_start;
  logic       run_start;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] pc;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       cpu_run;
  logic [3:0] load_addr;
  logic       loaded;

  modport master (
    output load_start, run_start, wr_valid, wr_data, pc,
    input  wr_ready, opcode, immediate, cpu_run, load_addr, loaded
  );

  modport slave (
    input  load_start, run_start, wr_valid, wr_data, pc,
    output wr_ready, opcode, immediate, cpu_run, load_addr, loaded
  );
endinterface

// File: rtl/td4_program_loader.sv
// TD4 program store: loads 16 bytes over a valid/ready port, then serves mem[pc]
// as registered opcode/immediate nibbles while the CPU runs.
module td4_program_loader #(
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  td4_program_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_mem [DEPTH];
  logic [3:0] r_load_addr;
  logic       r_loaded;
  logic [3:0] r_opcode;
  logic [3:0] r_immediate;
  logic       w_xfer;
  logic       w_last;
  logic       w_fetch;

  // load_start outranks everything, including a byte offered in the same cycle.
  always_comb begin
    w_next  = r_state;
    w_xfer  = 1'b0;
    w_last  = 1'b0;
    w_fetch = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_start)     w_next = ST_LOAD;
        else if (bus.run_start) w_next = ST_RUN;
      end
      ST_LOAD: begin
        if (bus.load_start) begin
          w_next = ST_LOAD;
        end else if (bus.wr_valid) begin
          w_xfer = 1'b1;
          if (r_load_addr == 4'hF) begin
            w_last = 1'b1;
            w_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.load_start) w_next = ST_LOAD;
        else                w_fetch = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_load_addr <= 4'h0;
      r_loaded    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.load_start) begin
        r_load_addr <= 4'h0;
        r_loaded    <= 1'b0;
      end else if (w_xfer) begin
        r_load_addr <= r_load_addr + 4'h1;
        if (w_last) r_loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_xfer) begin
      r_mem[r_load_addr] <= bus.wr_data;
    end
  end

  // Fetch is gated by the staying-in-RUN condition so a reload zeroes the
  // instruction on the same edge cpu_run drops.
  always_ff @(posedge clk) begin
    if (rst || !w_fetch) begin
      r_opcode    <= 4'h0;
      r_immediate <= 4'h0;
    end else begin
      {r_immediate, r_opcode} <= r_mem[bus.pc];
    end
  end

  assign bus.wr_ready  = (r_state == ST_LOAD);
  assign bus.cpu_run   = (r_state == ST_RUN);
  assign bus.load_addr = r_load_addr;
  assign bus.loaded    = r_loaded;
  assign bus.opcode    = r_opcode;
  assign bus.immediate = r_immediate;

endmodule

// File: tb/tb_td4_program_loader.sv
// Self-checking bench for td4_program_loader: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the program store.
module tb_td4_program_loader;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  td4_program_loader_if bus ();

  td4_program_loader #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 loading, 2 running
  int         m_mode;
  logic [7:0] m_mem [16];
  int         m_addr;
  logic       m_loaded;
  logic [7:0] m_instr;
  int         m_beats;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_addr = 0; m_loaded = 1'b0; m_instr = 8'h00;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      m_instr = (m_mode == 2 && !bus.load_start) ? m_mem[bus.pc] : 8'h00;
      if (bus.load_start) begin
        m_mode = 1; m_addr = 0; m_loaded = 1'b0;
      end else if (m_mode == 0) begin
        if (bus.run_start) m_mode = 2;
      end else if (m_mode == 1 && bus.wr_valid) begin
        m_mem[m_addr] = bus.wr_data;
        m_beats++;
        if (m_addr == 15) begin
          m_loaded = 1'b1;
          m_mode   = 2;
        end
        m_addr = (m_addr + 1) % 16;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("wr_ready",  bus.wr_ready,  (m_mode == 1));
    chk("cpu_run",   bus.cpu_run,   (m_mode == 2));
    chk("opcode",    bus.opcode,    m_instr[3:0]);
    chk("immediate", bus.immediate, m_instr[7:4]);
    chk("load_addr", bus.load_addr, m_addr[3:0]);
    chk("loaded",    bus.loaded,    m_loaded);
    bus.load_start = 1'b0;
    bus.run_start  = 1'b0;
    bus.wr_valid   = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic pulse_load();
    bus.load_start = 1'b1;
    cycle();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    cycle();
  endtask

  task automatic sweep_pc();
    for (int p = 0; p < 16; p++) begin
      bus.pc = p[3:0];
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.load_start = 1'b0; bus.run_start = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.pc = 4'h0;
    m_beats = 0;

    // Power-on reset
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_cpu_run", bus.cpu_run, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);

    // Full load of 0x10+i, then fetch
    pulse_load();
    for (int i = 0; i < 16; i++) send_byte(8'h10 + i[7:0]);
    chk("full_loaded", bus.loaded, 1'b1);
    chk("full_run", bus.cpu_run, 1'b1);
    chk("full_wrap_addr", bus.load_addr, 4'h0);
    chk("full_first_run_op", bus.opcode, 4'h0);
    bus.pc = 4'd3;
    cycle();
    chk("pc3_op", bus.opcode, 4'h3);
    chk("pc3_imm", bus.immediate, 4'h1);
    bus.pc = 4'd15;
    cycle();
    chk("pc15_op", bus.opcode, 4'hF);
    chk("pc15_imm", bus.immediate, 4'h1);
    // Wrap: pc 15 -> 0
    bus.pc = 4'd0;
    cycle();
    chk("pc0_op", bus.opcode, 4'h0);
    chk("pc0_imm", bus.immediate, 4'h1);

    // Reset mid-run for two cycles, then run without loading
    rst = 1'b1; cycle();
    rst = 1'b1; cycle();
    chk("midrst_loaded", bus.loaded, 1'b0);
    bus.run_start = 1'b1; bus.pc = 4'd5;
    cycle();
    cycle();
    cycle();
    chk("midrst_pc5_op", bus.opcode, 4'h0);
    chk("midrst_pc5_imm", bus.immediate, 4'h0);

    // Gapped handshake
    pulse_load();
    m_beats = 0;
    for (int i = 0; i < 32; i++) begin
      bus.wr_valid = i[0] ? 1'b0 : 1'b1;
      bus.wr_data  = 8'($urandom);
      cycle();
    end
    chk("gap_beats", m_beats, 16);
    chk("gap_loaded", bus.loaded, 1'b1);
    sweep_pc();
    bus.pc = 4'd0;
    cycle();

    // Restart mid-load with a simultaneous byte
    pulse_load();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    bus.load_start = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 8'hAA;
    cycle();
    chk("restart_addr", bus.load_addr, 4'h0);
    for (int i = 0; i < 16; i++) send_byte(8'h55);
    for (int p = 0; p < 16; p++) begin
      bus.pc = p[3:0];
      cycle();
      if (p > 0) begin
        chk("x55_op", bus.opcode, 4'h5);
        chk("x55_imm", bus.immediate, 4'h5);
      end
    end

    // Reload from RUN, partial write, reset, run without load
    pulse_load();
    chk("reload_run_drop", bus.cpu_run, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hC3);
    rst = 1'b1;
    cycle();
    bus.run_start = 1'b1;
    cycle();
    for (int p = 0; p < 16; p++) begin
      bus.pc = p[3:0];
      cycle();
      chk("norun_op", bus.opcode, 4'h0);
      chk("norun_imm", bus.immediate, 4'h0);
    end

    // load_start and run_start together after a full load
    pulse_load();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    cycle();
    bus.load_start = 1'b1;
    bus.run_start  = 1'b1;
    cycle();
    chk("prio_wr_ready", bus.wr_ready, 1'b1);
    chk("prio_cpu_run", bus.cpu_run, 1'b0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.load_start = ($urandom_range(0, 39) == 0);
      bus.run_start  = ($urandom_range(0, 19) == 0);
      bus.wr_valid   = $urandom_range(0, 3) != 0;
      bus.wr_data    = 8'($urandom);
      bus.pc         = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/td4_program_loader.md
# td4_program_loader

Program store and loader for the TD4 CPU test top. It accepts a 16-byte program over a byte-wide valid/ready write port and holds it in a 16x8 register file. In run mode it returns the instruction addressed by the CPU's 4-bit program counter, split into the opcode and immediate nibbles the CPU consumes. It is the instruction-supplying end of the CPU fetch interface and replaces driving opcode and immediate directly from pins.

## Interface

Parameters:
- DEPTH, 16, number of program entries. Fixed at 16 to match the 4-bit PC; other values are unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- load_start  in  1  single-cycle request to (re)start a program load.
- run_start  in  1  single-cycle request to enter run mode with the current memory contents.
- wr_valid  in  1  write byte valid.
- wr_data  in  8  program byte: [3:0] opcode, [7:4] immediate.
- wr_ready  out  1  loader accepts a byte this cycle.
- pc  in  4  CPU program counter.
- opcode  out  4  registered instruction opcode for mem[pc].
- immediate  out  4  registered instruction immediate for mem[pc].
- cpu_run  out  1  high while in RUN; the CPU advances only when it is high.
- load_addr  out  4  next memory address to be written.
- loaded  out  1  set after a complete 16-byte load; cleared by rst or by entering LOAD.

## Operation

- States: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE: wr_ready=0, cpu_run=0.
  - load_start -> LOAD, load_addr<=0, loaded<=0.
  - Else run_start -> RUN.
  - load_start has priority over run_start in every state.
- LOAD: wr_ready=1.
  - A transfer occurs when wr_valid&&wr_ready: mem[load_addr]<=wr_data, load_addr<=load_addr+1 (4-bit wrap).
  - The transfer at load_addr==15 sets loaded<=1, sets load_addr<=0 via wrap, and moves to RUN the next cycle.
  - load_start while in LOAD restarts at address 0. A byte presented in the same cycle is discarded and memory is not written.
  - run_start while in LOAD is ignored.
- RUN: cpu_run=1, wr_ready=0. Each cycle, {immediate,opcode}<=mem[pc].
  - load_start -> LOAD. Memory contents are preserved until overwritten byte by byte.
  - run_start while in RUN has no effect.
- Outside RUN, opcode and immediate register 0 every cycle, which is the TD4 encoding for "ADD A,0" and is harmless.
- wr_valid outside LOAD is ignored and no write occurs.
- Memory is never written in RUN, so there is no read/write collision.
- rst asserted mid-load or mid-run takes effect on that edge:
  - all 16 entries cleared to 0x00
  - state=IDLE
  - load_addr=0, loaded=0
  - opcode=0, immediate=0
  - cpu_run=0, wr_ready=0

## Timing

- Reset values: wr_ready=0, cpu_run=0, opcode=0, immediate=0, load_addr=0, loaded=0. All outputs are registered or decoded from the state register.
- The write handshake accepts one byte per cycle at full rate. wr_ready is high throughout LOAD, independent of wr_valid.
- A load takes 16 accepted beats. The first RUN cycle (cpu_run=1) follows the cycle of the 16th transfer.
- Fetch latency is 1 cycle: a pc value seen at edge N appears on opcode/immediate after edge N. The CPU samples the instruction one cycle after presenting pc.
- On entering RUN, the first cycle with cpu_run=1 still shows 0/0. Valid instruction data appears from the second RUN cycle.
- On load_start in RUN, cpu_run drops on the following edge and opcode/immediate read 0 from that edge.

## Test plan

- Reset: assert rst for 2 cycles mid-RUN. Required: cpu_run=0, opcode=0, immediate=0, loaded=0, load_addr=0; a subsequent run_start with pc=5 yields 0/0.
- Full load then fetch: load_start, stream bytes 0x10+i for i=0..15 with wr_valid constant high. Required: 16 transfers, loaded=1, cpu_run=1 on the next cycle; pc=3 yields opcode=3, immediate=1 one cycle later; pc=15 yields opcode=0xF, immediate=1.
- Gapped handshake: toggle wr_valid every other cycle during a load. Required: only valid cycles are written, load_addr advances exactly 16 times, and no byte is duplicated or lost.
- Restart mid-load: after 7 bytes, pulse load_start together with wr_valid carrying 0xAA. Required: load_addr=0, 0xAA not written; a new 16-byte load of 0x55 reads 0x5/0x5 at every pc.
- Reload from RUN and run without load: in RUN, pulse load_start. Required: cpu_run=0 next cycle. Write 3 bytes, then assert rst, then run_start. Required: all fetches return 0/0. Separately, after a full load, pulse load_start then run_start in a single later cycle. Required: load_start wins and the state is LOAD.
- Wrap: confirm load_addr reads 0 after the 16th transfer. Drive pc 15->0 in RUN. Required: the fetch returns mem[0] with 1-cycle latency.
